// File: rtl/bp_pkg.sv
// Shared BTB types: 2-bit direction counter, entry layout, key slicing helpers.
// Keys are fall-through addresses (branch PC + 1), so a lookup on NPC finds the branch.
package bp_pkg;

  localparam int ADDR_W = 16;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  // Tag is held full-width with the index bits shifted out, so the struct need not be parameterised.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [ADDR_W-1:0] target;
    ctr_t              ctr;
  } btb_entry_t;

  function automatic logic [ADDR_W-1:0] key_index(input logic [ADDR_W-1:0] key, input int idx_w);
    return key & ((16'd1 << idx_w) - 16'd1);
  endfunction

  function automatic logic [ADDR_W-1:0] key_tag(input logic [ADDR_W-1:0] key, input int idx_w);
    return key >> idx_w;
  endfunction

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) return (c == ST) ? ST : ctr_t'(c + 2'd1);
    else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/btb_array.sv
// BTB storage: one asynchronous lookup port, one read-modify-write update port committed at the clock edge.
// The update port applies the counter/target/allocate rules itself, so lookups see pre-update contents.
module btb_array
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output btb_entry_t        rd_entry,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [ADDR_W-1:0] upd_tag,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);

  btb_entry_t [ENTRIES-1:0] mem;
  btb_entry_t               cur;
  btb_entry_t               nxt;
  logic                     upd_hit;
  logic                     wr;

  assign rd_entry = mem[rd_idx];

  always_comb begin
    cur     = mem[upd_idx];
    upd_hit = cur.valid && (cur.tag == upd_tag);
    nxt     = cur;
    wr      = 1'b0;
    if (upd_en) begin
      if (upd_hit) begin
        wr      = 1'b1;
        nxt.ctr = ctr_next(cur.ctr, upd_taken);
        if (upd_taken) nxt.target = upd_target;
      end else if (upd_taken) begin
        // Taken miss claims the slot regardless of what lived there.
        wr  = 1'b1;
        nxt = '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: WT};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (wr) begin
      mem[upd_idx] <= nxt;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// BTB + 2-bit predictor: zero-latency lookup on NPC, one-cycle registered redirect/flush on mispredict.
// Resolves arriving while a redirect is pending are wrong-path and ignored.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc_if,
  output logic [15:0]       target_bp,
  output logic              target_en_bp,
  input  logic              resolve_valid_ex,
  input  logic [15:0]       resolve_pc_ex,
  input  logic              resolve_taken_ex,
  input  logic [15:0]       resolve_target_ex,
  input  logic              pred_taken_ex,
  input  logic [15:0]       pred_target_ex,
  output logic              flush,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [15:0]      res_key;
  btb_entry_t       lk;
  logic             lk_hit;
  logic             predict_taken;
  logic             accept;
  logic             mispredict;
  logic             redirect_pending;
  logic [15:0]      redirect_target;

  assign res_key = resolve_pc_ex + 16'd1;
  assign lk_idx  = IDX_W'(key_index(pc_if, IDX_W));
  assign upd_idx = IDX_W'(key_index(res_key, IDX_W));

  btb_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_btb (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (lk_idx),
    .rd_entry   (lk),
    .upd_en     (accept),
    .upd_idx    (upd_idx),
    .upd_tag    (key_tag(res_key, IDX_W)),
    .upd_taken  (resolve_taken_ex),
    .upd_target (resolve_target_ex)
  );

  assign lk_hit        = lk.valid && (lk.tag == key_tag(pc_if, IDX_W));
  assign predict_taken = lk_hit && lk.ctr[1];

  assign accept     = resolve_valid_ex && !redirect_pending;
  assign mispredict = accept &&
                      ((resolve_taken_ex != pred_taken_ex) ||
                       (resolve_taken_ex && (resolve_target_ex != pred_target_ex)));

  assign target_en_bp = redirect_pending || predict_taken;
  assign target_bp    = redirect_pending ? redirect_target : lk.target;
  assign flush        = redirect_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pending <= 1'b0;
      redirect_target  <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      redirect_pending <= mispredict;
      if (mispredict) redirect_target <= resolve_taken_ex ? resolve_target_ex : res_key;
      if (accept && (branch_count != '1)) branch_count <= branch_count + STAT_W'(1);
      if (mispredict && (mispredict_count != '1)) mispredict_count <= mispredict_count + STAT_W'(1);
    end
  end

endmodule
